// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO: storage array, binary pointers, occupancy and flag logic.
// Optional sticky overflow/underflow error flags when SYNC_FIFO_ERR_EN is defined.
module sync_fifo_ctrl #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned PTR_WIDTH  = 4,
    parameter int unsigned AF_THRESH  = 12,
    parameter int unsigned AE_THRESH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  w_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  r_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [PTR_WIDTH:0]    count
`ifdef SYNC_FIFO_ERR_EN
    ,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  err_clr
`endif
);

    localparam int unsigned CNT_W = PTR_WIDTH + 1;
    localparam logic [CNT_W-1:0] AF_LVL = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0] AE_LVL = CNT_W'(AE_THRESH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [CNT_W-1:0]      wptr;
    logic [CNT_W-1:0]      rptr;
    logic                  wr_ok;
    logic                  rd_ok;

    // Flags derive only from registered pointers, never from the requests.
    always_comb begin
        count        = wptr - rptr;
        empty        = (wptr == rptr);
        full         = (wptr[PTR_WIDTH] != rptr[PTR_WIDTH]) &&
                       (wptr[PTR_WIDTH-1:0] == rptr[PTR_WIDTH-1:0]);
        almost_full  = (count >= AF_LVL);
        almost_empty = (count <= AE_LVL);
        wr_ok        = w_en && !full;
        rd_ok        = r_en && !empty;
    end

    // Storage is not reset; contents are discarded logically via the pointers.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wptr[PTR_WIDTH-1:0]] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr       <= '0;
            rptr       <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
        end else begin
            data_valid <= rd_ok;
            if (wr_ok) begin
                wptr <= wptr + CNT_W'(1);
            end
            if (rd_ok) begin
                rptr     <= rptr + CNT_W'(1);
                data_out <= mem[rptr[PTR_WIDTH-1:0]];
            end
        end
    end

`ifdef SYNC_FIFO_ERR_EN
    // Sticky error flags; a new error in the clear cycle keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (w_en && full) begin
                overflow <= 1'b1;
            end else if (err_clr) begin
                overflow <= 1'b0;
            end
            if (r_en && empty) begin
                underflow <= 1'b1;
            end else if (err_clr) begin
                underflow <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Self-checking bench for sync_fifo_ctrl: queue-based reference model plus directed vectors.
module tb_sync_fifo_ctrl;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned PW    = 4;
    localparam int unsigned AF    = 12;
    localparam int unsigned AE    = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          w_en = 1'b0;
    logic          r_en = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] data_out;
    logic          data_valid, full, empty, almost_full, almost_empty;
    logic [PW:0]   count;
    logic          err_clr = 1'b0;
`ifdef SYNC_FIFO_ERR_EN
    logic          overflow, underflow;
`endif

    sync_fifo_ctrl #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .PTR_WIDTH(PW), .AF_THRESH(AF), .AE_THRESH(AE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .w_en(w_en), .data_in(data_in), .r_en(r_en),
        .data_out(data_out), .data_valid(data_valid), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count)
`ifdef SYNC_FIFO_ERR_EN
        , .overflow(overflow), .underflow(underflow), .err_clr(err_clr)
`endif
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    bit cmp_en  = 1'b0;

    // Reference model: a queue of stored words plus the registered read result.
    logic [DW-1:0] q[$];
    logic [DW-1:0] m_dout  = '0;
    logic          m_valid = 1'b0;
    logic          m_ovf   = 1'b0;
    logic          m_unf   = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_dout  = '0;
            m_valid = 1'b0;
            m_ovf   = 1'b0;
            m_unf   = 1'b0;
        end else begin
            int sz;
            sz = q.size();
            if (w_en && sz == DEPTH) m_ovf = 1'b1;
            else if (err_clr)        m_ovf = 1'b0;
            if (r_en && sz == 0)     m_unf = 1'b1;
            else if (err_clr)        m_unf = 1'b0;
            m_valid = 1'b0;
            if (r_en && sz > 0) begin
                m_dout  = q.pop_front();
                m_valid = 1'b1;
            end
            if (w_en && sz < DEPTH) q.push_back(data_in);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            int sz;
            sz = q.size();
            chk("m_count",  32'(count),        32'(sz));
            chk("m_empty",  32'(empty),        32'(sz == 0));
            chk("m_full",   32'(full),         32'(sz == DEPTH));
            chk("m_afull",  32'(almost_full),  32'(sz >= AF));
            chk("m_aempty", 32'(almost_empty), 32'(sz <= AE));
            chk("m_valid",  32'(data_valid),   32'(m_valid));
            chk("m_dout",   32'(data_out),     32'(m_dout));
`ifdef SYNC_FIFO_ERR_EN
            chk("m_ovf",    32'(overflow),     32'(m_ovf));
            chk("m_unf",    32'(underflow),    32'(m_unf));
`endif
        end
    end

    // Drive one cycle of requests; returns at the following negedge.
    task automatic step(input logic w, input logic r, input logic [DW-1:0] d);
        w_en = w; r_en = r; data_in = d;
        @(negedge clk);
        w_en = 1'b0; r_en = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] wv;
        #12;
        rst_n = 1'b1;
        cmp_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_aempty", 32'(almost_empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_dout", 32'(data_out), 32'd0);
        chk("rst_valid", 32'(data_valid), 32'd0);

        // Fill with 0x01..0x10
        for (int i = 1; i <= 16; i++) begin
            step(1'b1, 1'b0, DW'(i));
            chk("fill_count", 32'(count), 32'(i));
            chk("fill_afull", 32'(almost_full), 32'(i >= 12));
        end
        chk("fill_full", 32'(full), 32'd1);
        step(1'b1, 1'b0, 8'hAA);
        chk("drop_count", 32'(count), 32'd16);
        chk("drop_full", 32'(full), 32'd1);

        // Drain in order
        for (int i = 1; i <= 16; i++) begin
            step(1'b0, 1'b1, '0);
            chk("drain_dout", 32'(data_out), 32'(i));
            chk("drain_valid", 32'(data_valid), 32'd1);
            chk("drain_aempty", 32'(almost_empty), 32'(16 - i <= 4));
        end
        chk("drain_empty", 32'(empty), 32'd1);
        step(1'b0, 1'b1, '0);
        chk("urun_valid", 32'(data_valid), 32'd0);
        chk("urun_dout", 32'(data_out), 32'h10);

        // Simultaneous traffic at count 8 across pointer wrap
        wv = 8'h20;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, wv);
            wv++;
        end
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 1'b1, wv);
            wv++;
            chk("sim_count", 32'(count), 32'd8);
            chk("sim_dout", 32'(data_out), 32'(8'h20 + 8'(i)));
        end
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, '0);
        chk("sim_last", 32'(data_out), 32'(8'h20 + 8'd47));
        chk("sim_empty", 32'(empty), 32'd1);

        // Simultaneous at empty: no bypass
        step(1'b1, 1'b1, 8'h5C);
        chk("byp_valid", 32'(data_valid), 32'd0);
        chk("byp_count", 32'(count), 32'd1);
        step(1'b0, 1'b1, '0);
        chk("byp_dout", 32'(data_out), 32'h5C);
        chk("byp_valid2", 32'(data_valid), 32'd1);

`ifdef SYNC_FIFO_ERR_EN
        chk("err_unf_held", 32'(underflow), 32'd1);
        chk("err_ovf_held", 32'(overflow), 32'd1);
        err_clr = 1'b1;
        step(1'b0, 1'b0, '0);
        err_clr = 1'b0;
        chk("clr_ovf", 32'(overflow), 32'd0);
        chk("clr_unf", 32'(underflow), 32'd0);
        step(1'b0, 1'b1, '0);
        chk("unf_set", 32'(underflow), 32'd1);
        err_clr = 1'b1;
        step(1'b0, 1'b1, '0);
        err_clr = 1'b0;
        chk("unf_set_wins", 32'(underflow), 32'd1);
`endif

        // Reset in the middle of a write/read burst
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, DW'(8'h70 + i));
        w_en = 1'b1; r_en = 1'b1; data_in = 8'h99;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_empty", 32'(empty), 32'd1);
        chk("mrst_count", 32'(count), 32'd0);
        chk("mrst_valid", 32'(data_valid), 32'd0);
        chk("mrst_aempty", 32'(almost_empty), 32'd1);
`ifdef SYNC_FIFO_ERR_EN
        chk("mrst_ovf", 32'(overflow), 32'd0);
`endif
        w_en = 1'b0; r_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 1'b0, 8'h3E);
        step(1'b0, 1'b1, '0);
        chk("post_dout", 32'(data_out), 32'h3E);
        repeat (2) @(negedge clk);

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sync_fifo_ctrl.md
Name: sync_fifo_ctrl

Overview:
Single-clock FIFO for intra-domain buffering: parametrised storage array plus pointer, occupancy and flag logic in one block.
- Unlike the dual-clock memory slice, it owns its own pointers.
- Generates full/empty, almost-full/almost-empty and an occupancy count.
- Returns read data with a valid strobe.
- Used wherever producer and consumer share a clock and no synchroniser is needed.

Parameters:
- DATA_WIDTH, 8, width of each stored word.
- DEPTH, 16, number of entries; must be a power of 2, minimum 2.
- PTR_WIDTH, 4, log2(DEPTH); pointers are PTR_WIDTH+1 bits.
- AF_THRESH, 12, almost_full asserts when count >= AF_THRESH; range 1..DEPTH.
- AE_THRESH, 4, almost_empty asserts when count <= AE_THRESH; range 0..DEPTH-1.

Ports:
- clk, input, 1, single clock; all logic on rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- w_en, input, 1, write request.
- data_in, input, DATA_WIDTH, write data, sampled on accepted write.
- r_en, input, 1, read request.
- data_out, output, DATA_WIDTH, registered read data.
- data_valid, output, 1, one-cycle strobe: data_out updated this cycle.
- full, output, 1, count == DEPTH.
- empty, output, 1, count == 0.
- almost_full, output, 1, count >= AF_THRESH.
- almost_empty, output, 1, count <= AE_THRESH.
- count, output, PTR_WIDTH+1, current occupancy, 0..DEPTH.

Behaviour:
- Reset (rst_n low, async assert, sync release):
  - wptr = rptr = 0, data_out = 0, data_valid = 0.
  - empty = 1, full = 0, count = 0, almost_empty = 1, almost_full = 0.
  - Storage array is not reset.
- Pointers:
  - Binary, PTR_WIDTH+1 bits; low PTR_WIDTH bits address the array.
  - The MSB toggles on wrap from DEPTH-1 to 0.
- count = wptr - rptr, modulo 2^(PTR_WIDTH+1).
- full = (wptr[MSB] != rptr[MSB]) and (low bits equal).
- empty = (wptr == rptr).
- Flags and count are combinational from registered pointers only: they are glitch-free and reflect state after the last edge. No combinational path from w_en/r_en to any output.
- Accepted write: w_en & !full at posedge.
  - mem[wptr low] <= data_in; wptr += 1.
- Accepted read: r_en & !empty at posedge.
  - data_out <= mem[rptr low]; rptr += 1; data_valid <= 1 for exactly that following cycle.
  - Read latency is 1 clock from request edge to data_out/data_valid.
  - data_out holds its last value when no read is accepted; data_valid = 0 then.
- Rejected requests (write when full, read when empty):
  - No state change; silently dropped (see optional feature).
- Simultaneous w_en & r_en:
  - Not full, not empty: both accepted; count unchanged.
  - Full: read accepted, write rejected; count becomes DEPTH-1.
  - Empty: write accepted, read rejected; no write-to-read bypass; count becomes 1; data available for a read on the next cycle.
- Wrap-around: after 2*DEPTH accepted writes and reads, pointers return to 0 with correct flags throughout.
- Reset mid-operation: all contents are logically discarded (empty = 1 immediately on rst_n low); data_valid drops asynchronously.

Optional Feature:
SYNC_FIFO_ERR_EN
- Defined:
  - Adds ports overflow (output, 1), underflow (output, 1) and err_clr (input, 1).
  - overflow sets on a cycle with w_en & full; underflow sets on a cycle with r_en & empty.
  - Both are sticky until err_clr = 1 at a posedge, or reset.
  - Set wins over clear in the same cycle. Reset value 0.
- Not defined: ports and logic absent; rejected requests are silently dropped.

Test Plan:
- Reset, then idle 3 cycles -> empty = 1, almost_empty = 1, full = 0, count = 0, data_out = 0, data_valid = 0.
- Write 0x01..0x10 on consecutive cycles (DEPTH = 16) -> count steps 1..16.
  - almost_full rises the cycle after the 12th write.
  - full = 1 after the 16th write.
  - A 17th write of 0xAA is dropped; count stays 16.
- From full, read 16 consecutive cycles -> data_out = 0x01..0x10 in order, each one cycle after its r_en edge with data_valid = 1.
  - almost_empty rises when count = 4; empty = 1 after the last read.
- Simultaneous w_en & r_en for 40 cycles at count = 8 -> count stays 8 and reads return the in-order stream across pointer wrap.
- At empty, assert w_en = r_en = 1 with data_in = 0x5C -> read rejected (data_valid = 0), count = 1; r_en next cycle -> data_out = 0x5C.
- With SYNC_FIFO_ERR_EN:
  - Write when full -> overflow = 1 and stays set.
  - Read when empty -> underflow = 1.
  - Pulse err_clr -> both 0 next cycle.
  - Assert rst_n low mid-burst -> all flags and errors return to reset values.
